// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants, the search FSM state type and a 64-bit popcount helper
// used by the fingerprint match search block and its popcount sub-module.
// ---------------------------------------------------------------------------
package fp_pkg;

    localparam int ROW_W       = 256;  // bits per bitmap row
    localparam int ROWS        = 256;  // rows per bitmap
    localparam int ADDR_W      = 8;    // row address width
    localparam int SCORE_W     = 17;   // offset total / best score width
    localparam int OFF_W       = 5;    // signed vertical offset width
    localparam int ROW_SCORE_W = 9;    // per-row score, 0..256

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CMP,
        DONE
    } state_t;

    // Number of set bits in a 64-bit word (0..64).
    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_popcount256.sv
// ---------------------------------------------------------------------------
// fp_popcount256
// Two-stage pipelined popcount of a 256-bit row.
//   Stage 1: four 64-bit partial counts registered.
//   Stage 2: partial counts summed and registered.
// Ports:
//   clk    in   1    clock
//   rst_n  in   1    synchronous active-low reset
//   data   in   256  row to count
//   count  out  9    number of set bits in data, two cycles later
// ---------------------------------------------------------------------------
module fp_popcount256
    import fp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROW_W-1:0]       data,
    output logic [ROW_SCORE_W-1:0] count
);

    logic [6:0] part [4];

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) part[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < 4; i++) part[i] <= popcount64(data[i*64 +: 64]);
            count <= {2'b00, part[0]} + {2'b00, part[1]}
                   + {2'b00, part[2]} + {2'b00, part[3]};
        end
    end

endmodule

// File: rtl/fp_match_search.sv
// ---------------------------------------------------------------------------
// fp_match_search
// Scans the stored template and probe bitmaps over vertical offsets
// -SHIFT_MAX..+SHIFT_MAX. For each offset it sums popcount(template & probe)
// over all rows, keeps the best (earliest on ties) offset and flags a match
// when the best total reaches the sampled threshold.
//
// Optional feature: define FP_MATCH_XOR_PENALTY_EN to score each row as
//   max(0, popcount(t&p) - (popcount(t^p) >> 2)).
//
// Ports:
//   clk                  in   1    clock (also the store's search read clock)
//   rst_n                in   1    synchronous active-low reset
//   start                in   1    start pulse, accepted only in IDLE
//   abort                in   1    return to IDLE without a done pulse
//   thresh               in   17   match threshold, sampled on accepted start
//   search_out_add       out  8    template row address
//   search_out_add_test  out  8    probe row address
//   search_out_data      in   512  [255:0] probe row, [511:256] template row
//   busy                 out  1    scan in progress
//   done                 out  1    one-cycle pulse at scan completion
//   best_score           out  17   best offset total
//   best_offset          out  5    signed offset of best_score
//   match                out  1    best_score >= thresh
// ---------------------------------------------------------------------------
module fp_match_search
    import fp_pkg::*;
#(
    parameter int SHIFT_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SCORE_W-1:0]   thresh,
    output logic [ADDR_W-1:0]    search_out_add,
    output logic [ADDR_W-1:0]    search_out_add_test,
    input  logic [2*ROW_W-1:0]   search_out_data,
    output logic                 busy,
    output logic                 done,
    output logic [SCORE_W-1:0]   best_score,
    output logic [OFF_W-1:0]     best_offset,
    output logic                 match
);

    localparam logic [OFF_W-1:0]  OFF_FIRST = OFF_W'(-SHIFT_MAX);
    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(SHIFT_MAX);
    localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(ROWS - 1);

    state_t               state;
    logic [ADDR_W-1:0]    row;
    logic [1:0]           drain_cnt;
    logic [OFF_W-1:0]     off;        // current offset, two's complement
    logic [SCORE_W-1:0]   acc;        // total for the current offset
    logic [SCORE_W-1:0]   run_best;   // best total so far in this scan
    logic [OFF_W-1:0]     run_off;
    logic [SCORE_W-1:0]   thresh_q;
    logic                 v1, v2, v3; // row-valid mask alongside RAM q, stage 1, stage 2

    // ---------------- probe address generation ----------------
    // row + off in 10 bits: negative results set bit 9 and results of 256 or
    // more set bit 8, so the row is in range exactly when both are clear.
    logic [9:0] probe_row;
    logic       in_range;

    assign probe_row = {2'b00, row} + {{(10-OFF_W){off[OFF_W-1]}}, off};
    assign in_range  = (probe_row[9:8] == 2'b00);

    assign search_out_add      = (state == RUN) ? row : '0;
    assign search_out_add_test = (state == RUN && in_range) ? probe_row[ADDR_W-1:0] : '0;

    // ---------------- row scoring datapath ----------------
    logic [ROW_W-1:0]       tmpl_row, probe_row_data;
    logic [ROW_SCORE_W-1:0] and_cnt, row_score;

    assign probe_row_data = search_out_data[ROW_W-1:0];
    assign tmpl_row       = search_out_data[2*ROW_W-1:ROW_W];

    fp_popcount256 u_pop_and (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (tmpl_row & probe_row_data),
        .count (and_cnt)
    );

`ifdef FP_MATCH_XOR_PENALTY_EN
    logic [ROW_SCORE_W-1:0] xor_cnt, penalty;

    fp_popcount256 u_pop_xor (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (tmpl_row ^ probe_row_data),
        .count (xor_cnt)
    );

    // Penalty is a quarter of the mismatching bits; clamp at zero.
    assign penalty   = xor_cnt >> 2;
    assign row_score = (and_cnt > penalty) ? (and_cnt - penalty) : '0;
`else
    assign row_score = and_cnt;
`endif

    // ---------------- end-of-offset comparison ----------------
    // Strict greater-than keeps the earlier offset on ties.
    logic                 acc_better;
    logic [SCORE_W-1:0]   cmp_best;
    logic [OFF_W-1:0]     cmp_off;

    assign acc_better = (acc > run_best);
    assign cmp_best   = acc_better ? acc : run_best;
    assign cmp_off    = acc_better ? off : run_off;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= '0;
            drain_cnt   <= '0;
            off         <= '0;
            acc         <= '0;
            run_best    <= '0;
            run_off     <= '0;
            thresh_q    <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            best_score  <= '0;
            best_offset <= '0;
            match       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (abort) begin
                // Flush the valid mask so a restart cannot pick up rows
                // still in flight from the aborted scan.
                state <= IDLE;
                busy  <= 1'b0;
                v1    <= 1'b0;
                v2    <= 1'b0;
                v3    <= 1'b0;
            end else begin
                v1 <= (state == RUN) && in_range;
                v2 <= v1;
                v3 <= v2;
                if (v3) acc <= acc + {{(SCORE_W-ROW_SCORE_W){1'b0}}, row_score};

                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            row         <= '0;
                            off         <= OFF_FIRST;
                            acc         <= '0;
                            run_best    <= '0;
                            run_off     <= OFF_FIRST;
                            thresh_q    <= thresh;
                            best_score  <= '0;
                            best_offset <= '0;
                            match       <= 1'b0;
                        end
                    end

                    RUN: begin
                        row <= row + 1'b1;
                        if (row == ROW_LAST) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end

                    // Wait for the last row to clear RAM + two popcount stages
                    // + the accumulator.
                    DRAIN: begin
                        drain_cnt <= drain_cnt + 1'b1;
                        if (drain_cnt == 2'd3) state <= CMP;
                    end

                    CMP: begin
                        run_best <= cmp_best;
                        run_off  <= cmp_off;
                        acc      <= '0;
                        if (off == OFF_LAST) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            best_score  <= cmp_best;
                            best_offset <= cmp_off;
                            match       <= (cmp_best >= thresh_q);
                        end else begin
                            off   <= off + 1'b1;
                            row   <= '0;
                            state <= RUN;
                        end
                    end

                    DONE: state <= IDLE;

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_match_search.sv
// ---------------------------------------------------------------------------
// tb_fp_match_search
// Self-checking bench for fp_match_search. A behavioural store model serves
// both bitmaps with one cycle of read latency; a reference model computes the
// expected best score/offset straight from the scoring rules.
// ---------------------------------------------------------------------------
module tb_fp_match_search;
    import fp_pkg::*;

    localparam int SHIFT_MAX   = 8;
    localparam int SCAN_CYCLES = (2*SHIFT_MAX + 1) * 261 + 1;

    logic                 clk = 1'b0;
    logic                 rst_n, start, abort;
    logic [SCORE_W-1:0]   thresh;
    logic [ADDR_W-1:0]    search_out_add, search_out_add_test;
    logic [2*ROW_W-1:0]   search_out_data;
    logic                 busy, done, match;
    logic [SCORE_W-1:0]   best_score;
    logic [OFF_W-1:0]     best_offset;

    always #5 clk = ~clk;

    logic [ROW_W-1:0] tmem [ROWS];
    logic [ROW_W-1:0] pmem [ROWS];

    // Store read port: registered, one cycle of latency.
    always @(posedge clk) search_out_data <= {tmem[search_out_add], pmem[search_out_add_test]};

    fp_match_search #(.SHIFT_MAX(SHIFT_MAX)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .abort               (abort),
        .thresh              (thresh),
        .search_out_add      (search_out_add),
        .search_out_add_test (search_out_add_test),
        .search_out_data     (search_out_data),
        .busy                (busy),
        .done                (done),
        .best_score          (best_score),
        .best_offset         (best_offset),
        .match               (match)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int row_score_ref(input logic [ROW_W-1:0] t, input logic [ROW_W-1:0] p);
        int s;
        s = $countones(t & p);
`ifdef FP_MATCH_XOR_PENALTY_EN
        s = s - ($countones(t ^ p) / 4);
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic model(output int best, output int boff);
        int total;
        best = 0;
        boff = -SHIFT_MAX;
        for (int o = -SHIFT_MAX; o <= SHIFT_MAX; o++) begin
            total = 0;
            for (int r = 0; r < ROWS; r++) begin
                if (r + o >= 0 && r + o < ROWS) total += row_score_ref(tmem[r], pmem[r + o]);
            end
            if (total > best) begin
                best = total;
                boff = o;
            end
        end
    endtask

    function automatic logic [ROW_W-1:0] rand_row(input bit sparse);
        logic [ROW_W-1:0] v;
        for (int i = 0; i < 8; i++) begin
            if (sparse) v[i*32 +: 32] = $urandom & $urandom & $urandom & $urandom;
            else        v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic fill(input logic [ROW_W-1:0] t, input logic [ROW_W-1:0] p);
        for (int r = 0; r < ROWS; r++) begin
            tmem[r] = t;
            pmem[r] = p;
        end
    endtask

    task automatic pulse_start(input int thr);
        @(posedge clk); #1;
        thresh = SCORE_W'(thr);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Full scan with checks against the model. poke re-pulses start mid-scan
    // to confirm it is ignored while busy.
    task automatic run_scan(input int thr, input string tag, input bit poke,
                            output int eb, output int eo);
        int cnt;
        logic [OFF_W-1:0] eo5;
        logic [SCORE_W-1:0] held_score;
        model(eb, eo);
        eo5 = eo[OFF_W-1:0];
        pulse_start(thr);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!done && cnt < SCAN_CYCLES + 100) begin
            start = (poke && cnt == 500);
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cnt + 1, SCAN_CYCLES);
        check({tag, "_score"}, 32'(best_score), eb);
        check({tag, "_offset"}, 32'(best_offset), 32'(eo5));
        check({tag, "_match"}, 32'(match), 32'(eb >= thr));
        held_score = best_score;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_held"}, 32'(best_score), 32'(held_score));
        check({tag, "_match_held"}, 32'(match), 32'(eb >= thr));
    endtask

    initial begin
        int eb, eo;
        bit saw_done;

        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        thresh = '0;
        fill('0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_score", 32'(best_score), 32'd0);
        check("rst_offset", 32'(best_offset), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_add", 32'(search_out_add), 32'd0);
        check("rst_add_test", 32'(search_out_add_test), 32'd0);
        rst_n = 1'b1;

        // All-ones bitmaps; start re-pulsed mid-scan must be ignored.
        fill('1, '1);
        run_scan(60000, "ones", 1'b1, eb, eo);
        check("ones_spec_score", 32'(best_score), 32'd65536);
        check("ones_spec_offset", 32'(best_offset), 32'd0);

        // Probe is the template moved down by 3 rows.
        for (int r = 0; r < ROWS; r++) tmem[r] = rand_row(1'b1);
        for (int r = 0; r < ROWS; r++) pmem[r] = (r >= 3) ? tmem[r-3] : rand_row(1'b1);
        run_scan(100, "shift3", 1'b0, eb, eo);
        check("shift3_spec_offset", 32'(best_offset), 32'd3);
        check("shift3_spec_match", 32'(match), 32'd1);

        // All-zero: no offset beats zero, earliest offset reported.
        fill('0, '0);
        run_scan(1, "zero", 1'b0, eb, eo);
        check("zero_spec_offset", 32'(best_offset), 32'(5'b11000));

        // Template ones in the last 10 rows: offsets -8..0 tie, earliest wins.
        fill('0, '1);
        for (int r = ROWS - 10; r < ROWS; r++) tmem[r] = '1;
        run_scan(3000, "tie_hi", 1'b0, eb, eo);
        check("tie_hi_spec_score", 32'(best_score), 32'd2560);
        check("tie_hi_spec_offset", 32'(best_offset), 32'(5'b11000));

        // Template ones in the first 10 rows: offsets 0..8 tie.
        fill('0, '1);
        for (int r = 0; r < 10; r++) tmem[r] = '1;
        run_scan(2560, "tie_lo", 1'b0, eb, eo);

        // Dense random bitmaps, random threshold.
        for (int r = 0; r < ROWS; r++) begin
            tmem[r] = rand_row(1'b0);
            pmem[r] = rand_row(1'b0);
        end
        run_scan(int'($urandom_range(15000, 18000)), "rand", 1'b0, eb, eo);

        // Abort mid-scan at cycle 1000 after the start cycle.
        fill('1, '1);
        pulse_start(60000);
        repeat (999) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_score", 32'(best_score), 32'd0);
        check("abort_match", 32'(match), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);

        // Abort and start together while idle: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", 32'(busy), 32'd0);

        // Fresh start after abort completes normally.
        run_scan(60000, "restart", 1'b0, eb, eo);

        // Reset mid-scan clears everything.
        pulse_start(10);
        repeat (200) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_score", 32'(best_score), 32'd0);
        check("midrst_add", 32'(search_out_add), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done), 32'd0);

`ifdef FP_MATCH_XOR_PENALTY_EN
        // Alternate probe bits: 128 - 128/4 = 96 per row, 256 rows at offset 0.
        fill('1, {64{4'h5}});
        run_scan(20000, "xor_alt", 1'b0, eb, eo);
        check("xor_alt_spec_score", 32'(best_score), 32'd24576);

        // Zero probe: score clamps at zero.
        fill('1, '0);
        run_scan(1, "xor_zero", 1'b0, eb, eo);
        check("xor_zero_spec_score", 32'(best_score), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
